// File: rtl/scrypt_pkg.sv
// -----------------------------------------------------------------------------
// scrypt_pkg
// Shared constants and types for the scrypt nonce dispatcher.
//   HDR_W      : block header width handed to a scrypt core
//   HASH_W     : hash width returned by a scrypt core
//   NONCE_W    : nonce width
//   NONCE_LSB  : bit position of the nonce field inside the header
//   disp_state_e : dispatcher FSM state encoding
// -----------------------------------------------------------------------------
package scrypt_pkg;

  localparam int HDR_W     = 640;
  localparam int HASH_W    = 256;
  localparam int NONCE_W   = 32;
  localparam int NONCE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } disp_state_e;

endpackage

// File: rtl/scrypt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// scrypt_rr_arbiter
// Round-robin arbiter with grant lock.
//   clk, reset : clock, synchronous active-high reset
//   req[N]     : request vector (held results)
//   ack        : the currently granted request was consumed this cycle
//   grant[N]   : one-hot grant, all-zero when nothing is requested
// Once a grant is presented it stays locked on that index until ack, so a
// newly arriving request with higher priority cannot change what the
// consumer is looking at. After ack the priority pointer moves to the
// index just after the one served.
// -----------------------------------------------------------------------------
module scrypt_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] pick_idx, gnt_idx;
  logic          found, gnt_valid;
  int            idx;

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found    = 1'b1;
        pick_idx = IW'(idx);
      end
    end

    gnt_idx   = lock_q ? lock_idx_q : pick_idx;
    gnt_valid = lock_q | found;
    grant     = '0;
    if (gnt_valid) grant[gnt_idx] = 1'b1;

    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (gnt_valid && ack) begin
      lock_d = 1'b0;
      ptr_d  = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/scrypt_nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// scrypt_nonce_dispatcher
// Splits a mining job (header, nonce range, target) across NUM_CORES external
// scrypt cores and returns results through a single result port.
//   clk, reset            : clock, synchronous active-high reset
//   job_*                 : job input; job_ready is high only in IDLE
//   core_init/core_in     : per-core start pulse and header (nonce in [31:0])
//   core_out/core_valid   : per-core hash and completion strobe
//   res_*                 : result output (hit = hash <= target, unsigned)
//   busy                  : job active; done: one-cycle end-of-job pulse
//   state_dbg             : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised, it and its payload hold until ready.
// -----------------------------------------------------------------------------
module scrypt_nonce_dispatcher
  import scrypt_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int REPORT_ALL = 0,
  parameter int HDR_W      = scrypt_pkg::HDR_W,
  parameter int HASH_W     = scrypt_pkg::HASH_W,
  parameter int NONCE_W    = scrypt_pkg::NONCE_W,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [HDR_W-1:0]              job_header,
  input  logic [NONCE_W-1:0]            job_nonce_start,
  input  logic [NONCE_W-1:0]            job_nonce_count,
  input  logic [HASH_W-1:0]             job_target,
  output logic [NUM_CORES-1:0]          core_init,
  output logic [NUM_CORES*HDR_W-1:0]    core_in,
  input  logic [NUM_CORES*HASH_W-1:0]   core_out,
  input  logic [NUM_CORES-1:0]          core_valid,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [NONCE_W-1:0]            res_nonce,
  output logic [HASH_W-1:0]             res_hash,
  output logic                          res_hit,
  output logic [CORE_W-1:0]             res_core,
  output logic                          busy,
  output logic                          done,
  output disp_state_e                   state_dbg
);

  disp_state_e              state_q, state_d;
  logic [HDR_W-1:0]         hdr_q, hdr_d;
  logic [HASH_W-1:0]        target_q, target_d;
  logic [NONCE_W-1:0]       next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]       remain_q, remain_d;
  logic [NUM_CORES-1:0]     inflight_q, inflight_d;
  logic [NUM_CORES-1:0]     held_q, held_d;
  logic [NUM_CORES-1:0]     hit_q, hit_d;
  logic [NONCE_W-1:0]       nonce_q [NUM_CORES];
  logic [NONCE_W-1:0]       nonce_d [NUM_CORES];
  logic [NONCE_W-1:0]       issue_nonce [NUM_CORES];
  logic [HASH_W-1:0]        hash_q [NUM_CORES];
  logic [HASH_W-1:0]        hash_d [NUM_CORES];
  logic [NUM_CORES-1:0]     grant;
  logic                     res_ack;
  int                       issued;

  scrypt_rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (held_q),
    .ack   (res_ack),
    .grant (grant)
  );

  assign job_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;
  assign res_valid = |held_q;
  assign res_ack   = res_valid & res_ready;

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    target_d     = target_q;
    next_nonce_d = next_nonce_q;
    remain_d     = remain_q;
    inflight_d   = inflight_q;
    held_d       = held_q;
    hit_d        = hit_q;
    nonce_d      = nonce_q;
    hash_d       = hash_q;
    core_init    = '0;
    done         = 1'b0;
    issued       = 0;
    for (int c = 0; c < NUM_CORES; c++) issue_nonce[c] = '0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          hdr_d        = job_header;
          target_d     = job_target;
          next_nonce_d = job_nonce_start;
          remain_d     = job_nonce_count;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // Lowest free core index takes the lowest outstanding nonce. A core
        // is free only on registered flags, so one released this cycle waits
        // until the next cycle before it is started again.
        for (int c = 0; c < NUM_CORES; c++) begin
          issue_nonce[c] = next_nonce_q + NONCE_W'(issued);
          if (!reset && !inflight_q[c] && !held_q[c] &&
              (NONCE_W'(issued) < remain_q)) begin
            core_init[c]  = 1'b1;
            inflight_d[c] = 1'b1;
            nonce_d[c]    = issue_nonce[c];
            issued        = issued + 1;
          end
        end
        next_nonce_d = next_nonce_q + NONCE_W'(issued);
        remain_d     = remain_q - NONCE_W'(issued);
        if (remain_d == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (inflight_q == '0 && held_q == '0) begin
          done    = !reset;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completions only count for cores that were actually started.
    for (int c = 0; c < NUM_CORES; c++) begin
      if (inflight_q[c] && core_valid[c]) begin
        inflight_d[c] = 1'b0;
        hash_d[c]     = core_out[c*HASH_W +: HASH_W];
        hit_d[c]      = (core_out[c*HASH_W +: HASH_W] <= target_q);
        held_d[c]     = (REPORT_ALL != 0) || hit_d[c];
      end
      if (res_ack && grant[c]) held_d[c] = 1'b0;
    end
  end

  // Core header and result mux. During the start pulse the nonce comes from
  // the issue path; afterwards from the per-core register, which holds the
  // same value, so core_in does not move while the core works.
  always_comb begin
    core_in   = '0;
    res_nonce = '0;
    res_hash  = '0;
    res_hit   = 1'b0;
    res_core  = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_in[c*HDR_W +: HDR_W] = hdr_q;
      core_in[c*HDR_W + NONCE_LSB +: NONCE_W] = core_init[c] ? issue_nonce[c] : nonce_q[c];
      if (grant[c]) begin
        res_nonce = nonce_q[c];
        res_hash  = hash_q[c];
        res_hit   = hit_q[c];
        res_core  = CORE_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      target_q     <= '0;
      next_nonce_q <= '0;
      remain_q     <= '0;
      inflight_q   <= '0;
      held_q       <= '0;
      hit_q        <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        nonce_q[c] <= '0;
        hash_q[c]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      target_q     <= target_d;
      next_nonce_q <= next_nonce_d;
      remain_q     <= remain_d;
      inflight_q   <= inflight_d;
      held_q       <= held_d;
      hit_q        <= hit_d;
      for (int c = 0; c < NUM_CORES; c++) begin
        nonce_q[c] <= nonce_d[c];
        hash_q[c]  <= hash_d[c];
      end
    end
  end

endmodule

// File: tb/tb_scrypt_nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_scrypt_nonce_dispatcher
// Bench for scrypt_nonce_dispatcher with four stub cores of fixed latency 10.
// Expected results are derived from the job (start, count, target) alone.
// -----------------------------------------------------------------------------
module tb_scrypt_nonce_dispatcher;

  localparam int NC  = 4;
  localparam int LAT = 10;
  localparam int RA  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [639:0]     job_header = '0;
  logic [31:0]      job_nonce_start = '0;
  logic [31:0]      job_nonce_count = '0;
  logic [255:0]     job_target = '0;
  logic [NC-1:0]    core_init;
  logic [NC*640-1:0] core_in;
  logic [NC*256-1:0] core_out = '0;
  logic [NC-1:0]    core_valid = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_nonce;
  logic [255:0]     res_hash;
  logic             res_hit;
  logic [1:0]       res_core;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  scrypt_nonce_dispatcher #(.NUM_CORES(NC), .REPORT_ALL(RA)) dut (
    .clk             (clk),
    .reset           (reset),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_nonce_start (job_nonce_start),
    .job_nonce_count (job_nonce_count),
    .job_target      (job_target),
    .core_init       (core_init),
    .core_in         (core_in),
    .core_out        (core_out),
    .core_valid      (core_valid),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_nonce       (res_nonce),
    .res_hash        (res_hash),
    .res_hit         (res_hit),
    .res_core        (res_core),
    .busy            (busy),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  logic [31:0]  cur_start;
  logic [31:0]  cur_count;
  logic [255:0] cur_target;
  logic [639:0] cur_hdr;
  int init_cnt, res_cnt, done_cnt, accept_cyc, done_cyc;
  int cyc = 0;
  int rr_mode = 0;           // 0: always ready, 1: random, 2: held low
  int order_left = 0;
  int exp_core_next = 0;
  int epoch = 0;

  int           stub_cnt   [NC];
  logic         stub_busy  [NC];
  logic [639:0] stub_hdr   [NC];
  logic [31:0]  stub_nonce [NC];
  int           stub_epoch [NC];

  logic         prev_stall = 1'b0;
  logic [31:0]  prev_nonce;
  logic [255:0] prev_hash;
  logic [1:0]   prev_core;
  logic [31:0]  exp_n;
  int           found_idx;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stub core hash: any fixed function of the nonce will do.
  function automatic logic [255:0] stub_hash(input logic [31:0] n);
    logic [31:0] m;
    m = n * 32'h9E37_79B1;
    return {m, {7{n ^ 32'h5A5A_C3C3}}};
  endfunction

  initial begin
    for (int c = 0; c < NC; c++) begin
      stub_cnt[c] = 0; stub_busy[c] = 1'b0; stub_hdr[c] = '0;
      stub_nonce[c] = '0; stub_epoch[c] = 0;
    end
  end

  // ---------------- stub cores, res_ready driver, monitor ----------------
  always @(negedge clk) begin
    cyc++;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase

    for (int c = 0; c < NC; c++) begin
      core_valid[c] = 1'b0;
      if (stub_busy[c]) begin
        stub_cnt[c]--;
        if (stub_cnt[c] == 0) begin
          core_valid[c] = 1'b1;
          core_out[c*256 +: 256] = stub_hash(stub_hdr[c][31:0]);
          stub_busy[c] = 1'b0;
          if (stub_epoch[c] == epoch)
            check_eq("core_in_stable", core_in[c*640 +: 640] == stub_hdr[c], 1);
        end
      end
      if (!reset && core_init[c]) begin
        check_eq("init_core_idle", stub_busy[c], 0);
        exp_n = cur_start + 32'(init_cnt);
        check_eq("init_nonce", core_in[c*640 +: 32], exp_n);
        check_eq("init_hdr", core_in[c*640+32 +: 608] == cur_hdr[639:32], 1);
        init_cnt++;
        stub_busy[c]  = 1'b1;
        stub_cnt[c]   = LAT;
        stub_hdr[c]   = core_in[c*640 +: 640];
        stub_nonce[c] = core_in[c*640 +: 32];
        stub_epoch[c] = epoch;
      end
    end

    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (job_valid && job_ready) accept_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall) begin
        check_eq("res_stable", {res_valid, res_core, res_nonce}, {1'b1, prev_core, prev_nonce});
        check_eq("res_hash_stable", res_hash, prev_hash);
      end
      if (res_valid && res_ready) begin
        res_cnt++;
        found_idx = -1;
        foreach (exp_q[i]) if (found_idx < 0 && exp_q[i] == res_nonce) found_idx = i;
        check_eq("res_expected", found_idx >= 0, 1);
        if (found_idx >= 0) exp_q.delete(found_idx);
        check_eq("res_hash", res_hash, stub_hash(res_nonce));
        check_eq("res_hit", res_hit, stub_hash(res_nonce) <= cur_target);
        check_eq("res_core_nonce", stub_nonce[res_core], res_nonce);
        if (order_left > 0) begin
          check_eq("rr_order", res_core, exp_core_next);
          exp_core_next++;
          order_left--;
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_nonce = res_nonce;
      prev_hash  = res_hash;
      prev_core  = res_core;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [31:0] s, input logic [31:0] n, input logic [255:0] t);
    logic [31:0] nn;
    bit seen;
    cur_start = s; cur_count = n; cur_target = t;
    for (int w = 0; w < 20; w++) cur_hdr[w*32 +: 32] = $urandom();
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      nn = s + 32'(i);
      if (RA != 0 || stub_hash(nn) <= t) exp_q.push_back(nn);
    end
    init_cnt = 0; res_cnt = 0; done_cnt = 0; accept_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    job_valid = 1'b1; job_header = cur_hdr; job_nonce_start = s;
    job_nonce_count = n; job_target = t;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = job_ready;
    end
    check_eq("job_accepted", seen, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    @(negedge clk);
    check_eq("busy_after_accept", busy, 1);
    check_eq("first_dispatch", core_init != '0, n != 0);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk);
    check_eq("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt, 1);
    check_eq("init_count", init_cnt, cur_count);
    check_eq("results_left", exp_q.size(), 0);
    check_eq("idle_ready", job_ready, 1);
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_job_ready"}, job_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_core_init"}, core_init, 0);
    check_eq({tag, "_core_in"}, |core_in, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_fields"}, {res_nonce, res_hit, res_core} == '0 && res_hash == '0, 1);
  endtask

  function automatic logic [255:0] rand_target();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom();
    return t;
  endfunction

  // ---------------- test sequence ----------------
  int snap_res, snap_done;
  bit got;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("rst");

    // All four cores finish together while results are back-pressured.
    rr_mode = 2;
    start_job($urandom(), 32'd8, {256{1'b1}});
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = res_valid;
    end
    check_eq("hold_valid", got, 1);
    check_eq("hold_inits", init_cnt, 4);
    repeat (50) @(negedge clk);
    check_eq("no_redispatch", init_cnt, 4);
    check_eq("hold_res_cnt", res_cnt, 0);
    exp_core_next = 0;
    order_left = 4;
    rr_mode = 0;
    wait_done(1000);
    check_eq("hold_total", res_cnt, 8);

    // Basic job, every hash is a hit.
    rr_mode = 0;
    start_job(32'h0000_0100, 32'd8, {256{1'b1}});
    wait_done(1000);
    check_eq("allhit_count", res_cnt, 8);

    // Target zero: nothing reported.
    rr_mode = 1;
    start_job($urandom(), 32'd20, '0);
    wait_done(1000);
    check_eq("zero_target_res", res_cnt, 0);

    // Nonce counter wrap.
    start_job(32'hFFFF_FFFE, 32'd4, rand_target());
    wait_done(1000);

    // Empty job.
    start_job($urandom(), 32'd0, rand_target());
    wait_done(50);
    check_eq("empty_done_latency", done_cyc - accept_cyc, 2);

    // Reset in the middle of a job.
    rr_mode = 0;
    start_job($urandom(), 32'd100, {256{1'b1}});
    for (int k = 0; k < 300 && init_cnt < 5; k++) @(negedge clk);
    check_eq("reached_5_inits", init_cnt >= 5, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    epoch++;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    snap_res = res_cnt;
    snap_done = done_cnt;
    @(negedge clk);
    check_zero_outputs("midrst");
    repeat (20) @(negedge clk);
    check_eq("midrst_no_res", res_cnt, snap_res);
    check_eq("midrst_no_done", done_cnt, snap_done);
    rr_mode = 1;
    start_job($urandom(), 32'd13, rand_target());
    wait_done(2000);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      rr_mode = $urandom_range(0, 1);
      start_job($urandom(), 32'($urandom_range(1, 30)), rand_target());
      wait_done(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scrypt_nonce_dispatcher.md
SCRYPT_NONCE_DISPATCHER -- requirements
Module: scrypt_nonce_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of attached scrypt cores (1..16).
REQ-002 SHALL have parameter REPORT_ALL, default 0; 0 reports only target hits, 1 reports every hash.
REQ-003 SHALL have parameters HDR_W 640, HASH_W 256, NONCE_W 32; header and hash widths, fixed by core.
REQ-004 SHALL have port: clk  in  1  single clock, rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: job_valid in 1, job_ready out 1; job handshake.
REQ-007 SHALL have ports: job_header in 640, job_nonce_start in 32, job_nonce_count in 32, job_target in 256.
REQ-008 SHALL have ports: core_init out NUM_CORES, core_in out NUM_CORES*640; per-core start pulse and header.
REQ-009 SHALL have ports: core_out in NUM_CORES*256, core_valid in NUM_CORES; per-core hash and done.
REQ-010 SHALL have ports: res_valid out 1, res_ready in 1, res_nonce out 32, res_hash out 256, res_hit out 1, res_core out clog2(NUM_CORES).
REQ-011 SHALL have ports: busy out 1 (job active), done out 1 (one-cycle end-of-job pulse).

Function
REQ-012 FSM states: IDLE, RUN, FLUSH; IDLE->RUN on job_valid&job_ready; RUN->FLUSH when all nonces issued; FLUSH->IDLE when every core idle and no held result.
REQ-013 job_ready SHALL be 1 only in IDLE; job fields latched on acceptance.
REQ-014 Core header: latched header with bits[31:0] replaced by the issued nonce, unchanged bit order.
REQ-015 Nonces issued sequentially from nonce_start, lowest free core index first; one nonce per free core per cycle, several cores per cycle allowed.
REQ-016 Nonce counter SHALL wrap 0xFFFFFFFF->0x00000000 without error.
REQ-017 core_init SHALL be a one-cycle pulse; core_in stable from that pulse until that core's core_valid.
REQ-018 First dispatch SHALL occur the cycle after job acceptance (latency 1).
REQ-019 On core_valid, hash captured into that core's hold register with its nonce; hit = (hash <= target), unsigned 256-bit.
REQ-020 Non-reported results (REPORT_ALL=0, no hit) SHALL free the core the same cycle; reported results free it when accepted on res port.
REQ-021 Freed core SHALL be re-dispatched no earlier than the next cycle.
REQ-022 Held results SHALL be drained round-robin over cores; res_* stable while res_valid&!res_ready.
REQ-023 Simultaneous core_valid on several cores: all captured that cycle, none lost.
REQ-024 core_valid on a core not in flight SHALL be ignored.
REQ-025 nonce_count = 0: no core_init; done pulses 2 cycles after acceptance.
REQ-026 done SHALL pulse on the FLUSH->IDLE transition; busy = (state != IDLE).

Reset
REQ-027 reset SHALL force IDLE; job_ready=1 the cycle after release, all other outputs 0.
REQ-028 reset mid-job SHALL discard in-flight and held results; no done pulse; later core_valid ignored.

Structure
REQ-029 Package scrypt_pkg SHALL hold HDR_W, HASH_W, NONCE_W, nonce bit position and the FSM state typedef.
REQ-030 Round-robin arbiter SHALL be sub-module scrypt_rr_arbiter (parameter N, request/grant/ack).
REQ-031 Core instances SHALL stay outside this block.

Verification
REQ-032 Stub cores, fixed latency 10: start 0x100, count 8, target all-ones -> 8 results, nonces 0x100..0x107 each once, all res_hit=1, one done.
REQ-033 Target 0 with REPORT_ALL=0, count 20 -> no res_valid, done asserted, exactly 20 core_init pulses.
REQ-034 Start 0xFFFFFFFE, count 4 -> issued nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-035 All 4 cores core_valid same cycle, res_ready held 0 for 50 cycles -> no re-dispatch, 4 results drained in order core0..3 after release.
REQ-036 reset after 5 dispatched nonces -> outputs 0 next cycle, no res_valid/done; fresh job then completes normally.
REQ-037 count 0 -> done 2 cycles after acceptance, zero core_init.
